string_packer: RTL and testbench

- Transmit-side counterpart of the string comparator.
- Serializes a flagged string of up to 17 bytes into the same 32-bit word stream format the comparator consumes. The string can start at any byte lane, 0–3, and unused bytes are padded with a fill byte.
- Used to inject URL/keyword patterns into the sniffer datapath, both for self-test and for replaying flagged content to the comparator under a valid/ready handshake.

---
 rtl/string_packer_if.sv | 10 +
 rtl/string_packer.sv | 182 ++++++++++++++++++
 tb/tb_string_packer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/string_packer_if.sv
// Word-stream handshake between the string packer and its consumer.
// The master drives data_out/data_valid and the slave answers with ready_in.
interface string_packer_if;
   logic [31:0] data_out;
   logic        data_valid;
   logic        ready_in;

   modport master (output data_out, output data_valid, input ready_in);
   modport slave  (input data_out, input data_valid, output ready_in);
endinterface

// File: rtl/string_packer.sv
// Serializes a string of up to MAX_LEN bytes, starting at any byte lane, into
// big-endian 32-bit words padded with a fill byte, under a valid/ready handshake.
module string_packer #(
   parameter int MAX_LEN = 17,
   parameter int LEN_W   = 5
) (
   input  logic                      clk,
   input  logic                      n_rst,
   input  logic                      clear,
   input  logic                      start,
   input  logic [0:MAX_LEN-1][7:0]   flagged_string,
   input  logic [LEN_W-1:0]          strlen,
   input  logic [1:0]                offset,
   input  logic [7:0]                fill_byte,
   string_packer_if.master           bus,
   output logic                      busy,
   output logic                      done
);

   localparam int P_W   = LEN_W + 1;
   localparam int K_W   = P_W - 2;
   localparam int IDX_W = $clog2(MAX_LEN);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t                    r_state, w_state_next;
   logic [0:MAX_LEN-1][7:0]   r_bytes, w_bytes_next;
   logic [1:0]                r_offset, w_offset_next;
   logic [7:0]                r_fill, w_fill_next;
   logic [LEN_W-1:0]          r_len, w_len_next;
   logic [K_W-1:0]            r_words, w_words_next;
   logic [K_W-1:0]            r_idx, w_idx_next;
   logic [31:0]               r_data, w_data_next;
   logic                      r_valid, w_valid_next;
   logic                      r_busy, w_busy_next;
   logic                      r_done, w_done_next;

   logic [LEN_W-1:0]          w_len;
   logic [P_W-1:0]            w_sum;
   logic [K_W-1:0]            w_num_words;
   logic [K_W-1:0]            w_idx_inc;
   logic [31:0]               w_first_word;
   logic [31:0]               w_following_word;

   // Stream position p = 4k + j carries byte (p - off) inside the string window, else fill.
   function automatic logic [31:0] build_word(
      input logic [0:MAX_LEN-1][7:0] b,
      input logic [1:0]              off,
      input logic [LEN_W-1:0]        len,
      input logic [7:0]              fill,
      input logic [K_W-1:0]          k
   );
      logic [31:0]      w;
      logic [P_W-1:0]   p;
      logic [P_W-1:0]   lo;
      logic [P_W-1:0]   hi;
      logic [IDX_W-1:0] idx;
      w  = '0;
      lo = P_W'(off);
      hi = lo + P_W'(len);
      for (int j = 0; j < 4; j++) begin
         p = {k, 2'b00} + P_W'(j);
         if (p >= lo && p < hi) begin
            idx = IDX_W'(p - lo);
            w[31-8*j -: 8] = b[idx];
         end else begin
            w[31-8*j -: 8] = fill;
         end
      end
      return w;
   endfunction

   assign w_len            = (strlen > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : strlen;
   assign w_sum            = P_W'(offset) + P_W'(w_len) + P_W'(3);
   assign w_num_words      = w_sum[P_W-1:2];
   assign w_idx_inc        = r_idx + K_W'(1);
   assign w_first_word     = build_word(flagged_string, offset, w_len, fill_byte, '0);
   assign w_following_word = build_word(r_bytes, r_offset, r_len, r_fill, w_idx_inc);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state  <= IDLE;
         r_bytes  <= '0;
         r_offset <= '0;
         r_fill   <= '0;
         r_len    <= '0;
         r_words  <= '0;
         r_idx    <= '0;
         r_data   <= '0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_bytes  <= w_bytes_next;
         r_offset <= w_offset_next;
         r_fill   <= w_fill_next;
         r_len    <= w_len_next;
         r_words  <= w_words_next;
         r_idx    <= w_idx_next;
         r_data   <= w_data_next;
         r_valid  <= w_valid_next;
         r_busy   <= w_busy_next;
         r_done   <= w_done_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_bytes_next  = r_bytes;
      w_offset_next = r_offset;
      w_fill_next   = r_fill;
      w_len_next    = r_len;
      w_words_next  = r_words;
      w_idx_next    = r_idx;
      w_data_next   = r_data;
      w_valid_next  = r_valid;
      w_busy_next   = r_busy;
      w_done_next   = 1'b0;

      if (clear) begin
         w_state_next = IDLE;
         w_idx_next   = '0;
         w_data_next  = '0;
         w_valid_next = 1'b0;
         w_busy_next  = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  w_bytes_next  = flagged_string;
                  w_offset_next = offset;
                  w_fill_next   = fill_byte;
                  w_len_next    = w_len;
                  w_words_next  = w_num_words;
                  w_idx_next    = '0;
                  w_busy_next   = 1'b1;
                  if (w_num_words == '0) begin
                     w_state_next = DONE;
                  end else begin
                     w_state_next = SEND;
                     w_data_next  = w_first_word;
                     w_valid_next = 1'b1;
                  end
               end
            end
            SEND: begin
               if (bus.ready_in) begin
                  if (r_idx == r_words - K_W'(1)) begin
                     w_state_next = DONE;
                     w_valid_next = 1'b0;
                     w_done_next  = 1'b1;
                  end else begin
                     w_idx_next  = w_idx_inc;
                     w_data_next = w_following_word;
                  end
               end
            end
            DONE: begin
               // An empty string enters DONE without a pulse; raise it on the second cycle.
               if (r_done) begin
                  w_state_next = IDLE;
                  w_busy_next  = 1'b0;
               end else begin
                  w_done_next = 1'b1;
               end
            end
            default: begin
               w_state_next = IDLE;
               w_valid_next = 1'b0;
               w_busy_next  = 1'b0;
            end
         endcase
      end
   end

   assign bus.data_out   = r_data;
   assign bus.data_valid = r_valid;
   assign busy           = r_busy;
   assign done           = r_done;

endmodule

// File: tb/tb_string_packer.sv
// Directed bench for string_packer: hand-computed word streams, backpressure,
// empty/full-length strings, clear and asynchronous reset aborts.
module tb_string_packer;
   logic              clk = 1'b0;
   logic              n_rst = 1'b0;
   logic              clear = 1'b0;
   logic              start = 1'b0;
   logic [0:16][7:0]  fs = '0;
   logic [4:0]        strlen = '0;
   logic [1:0]        offset = '0;
   logic [7:0]        fill_byte = '0;
   logic              busy;
   logic              done;

   int n_chk  = 0;
   int n_pass = 0;
   logic [31:0] exp_q[$];

   string_packer_if bus ();

   string_packer dut (
      .clk            (clk),
      .n_rst          (n_rst),
      .clear          (clear),
      .start          (start),
      .flagged_string (fs),
      .strlen         (strlen),
      .offset         (offset),
      .fill_byte      (fill_byte),
      .bus            (bus),
      .busy           (busy),
      .done           (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [0:16][7:0] str2bytes(input string s);
      logic [0:16][7:0] b;
      b = '0;
      for (int i = 0; i < 17; i++) if (i < s.len()) b[i] = s[i];
      return b;
   endfunction

   // Pulse start for one edge, then scramble the inputs to prove they were latched.
   task automatic send(input logic [0:16][7:0] b, input int len, input int off, input logic [7:0] fill);
      fs = b; strlen = len[4:0]; offset = off[1:0]; fill_byte = fill;
      start = 1'b1;
      tick();
      start = 1'b0;
      fs = '0; strlen = 5'd2; offset = 2'd1; fill_byte = 8'h5A;
   endtask

   task automatic expect_stream(input string tag);
      int n;
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
         chk({tag, "_valid"}, {31'b0, bus.data_valid}, 32'd1);
         chk({tag, "_word"}, bus.data_out, exp_q[k]);
         tick();
      end
      chk({tag, "_done"}, {31'b0, done}, 32'd1);
      chk({tag, "_valid_off"}, {31'b0, bus.data_valid}, 32'd0);
      tick();
      chk({tag, "_done_once"}, {31'b0, done}, 32'd0);
      chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
      $display("string %s: %0d words", tag, n);
      exp_q.delete();
   endtask

   initial begin
      bus.ready_in = 1'b1;
      #3;
      chk("rst_data", bus.data_out, 32'h0);
      chk("rst_valid", {31'b0, bus.data_valid}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      tick();
      n_rst = 1'b1;
      tick();

      // 1: basic stream, offset 0
      send(str2bytes("www.google.com"), 14, 0, 8'h20);
      exp_q = '{"www.", "goog", "le.c", "om  "};
      expect_stream("google_off0");

      // 2: offset 3 and short strings at every lane
      send(str2bytes("www.google.com"), 14, 3, 8'h20);
      exp_q = '{"   w", "ww.g", "oogl", "e.co", "m   "};
      expect_stream("google_off3");
      send(str2bytes("abc"), 3, 0, 8'h20);
      exp_q = '{"abc "};
      expect_stream("abc_off0");
      send(str2bytes("abc"), 3, 1, 8'h20);
      exp_q = '{" abc"};
      expect_stream("abc_off1");
      send(str2bytes("abc"), 3, 2, 8'h20);
      exp_q = '{"  ab", "c   "};
      expect_stream("abc_off2");
      send(str2bytes("abc"), 3, 3, 8'h20);
      exp_q = '{"   a", "bc  "};
      expect_stream("abc_off3");

      // 3: full length and clamping
      send(str2bytes("www.linkedin.com/"), 17, 0, 8'h20);
      exp_q = '{"www.", "link", "edin", ".com", "/   "};
      expect_stream("linkedin_17");
      send(str2bytes("www.linkedin.com/"), 20, 0, 8'h20);
      exp_q = '{"www.", "link", "edin", ".com", "/   "};
      expect_stream("linkedin_20");

      // 4: backpressure on word 1, with a stray start while busy
      send(str2bytes("www.google.com"), 14, 0, 8'h20);
      chk("bp_w0", bus.data_out, "www.");
      tick();
      bus.ready_in = 1'b0;
      chk("bp_w1", bus.data_out, "goog");
      for (int c = 0; c < 3; c++) begin
         fs = str2bytes("abc"); strlen = 5'd3; offset = 2'd0;
         start = (c == 1);
         tick();
         start = 1'b0;
         chk("bp_hold", bus.data_out, "goog");
         chk("bp_hold_valid", {31'b0, bus.data_valid}, 32'd1);
      end
      bus.ready_in = 1'b1;
      tick();
      chk("bp_w2", bus.data_out, "le.c");
      tick();
      chk("bp_w3", bus.data_out, "om  ");
      tick();
      chk("bp_done", {31'b0, done}, 32'd1);
      chk("bp_valid_off", {31'b0, bus.data_valid}, 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("bp_no_extra", {31'b0, bus.data_valid | done}, 32'd0);
      end

      // 5: empty string, all-ones and all-zeros
      send(str2bytes(""), 0, 0, 8'h20);
      chk("len0_valid_n1", {31'b0, bus.data_valid}, 32'd0);
      chk("len0_busy_n1", {31'b0, busy}, 32'd1);
      chk("len0_done_n1", {31'b0, done}, 32'd0);
      tick();
      chk("len0_done_n2", {31'b0, done}, 32'd1);
      chk("len0_valid_n2", {31'b0, bus.data_valid}, 32'd0);
      tick();
      chk("len0_done_n3", {31'b0, done}, 32'd0);
      chk("len0_idle", {31'b0, busy}, 32'd0);
      send({17{8'hFF}}, 17, 0, 8'hFF);
      exp_q = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      expect_stream("ones");
      send('0, 17, 0, 8'h00);
      exp_q = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      expect_stream("zeros");

      // 6: clear during word 2, then a clean restart
      send(str2bytes("www.google.com"), 14, 0, 8'h20);
      tick();
      tick();
      chk("clr_w2", bus.data_out, "le.c");
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_valid", {31'b0, bus.data_valid}, 32'd0);
      chk("clr_data", bus.data_out, 32'h0);
      chk("clr_busy", {31'b0, busy}, 32'd0);
      chk("clr_done", {31'b0, done}, 32'd0);
      tick();
      chk("clr_no_done", {31'b0, done}, 32'd0);
      send(str2bytes("www.google.com"), 14, 0, 8'h20);
      exp_q = '{"www.", "goog", "le.c", "om  "};
      expect_stream("after_clear");

      // start and clear together: clear wins
      fs = str2bytes("abc"); strlen = 5'd3; offset = 2'd0;
      start = 1'b1; clear = 1'b1;
      tick();
      start = 1'b0; clear = 1'b0;
      chk("startclr_valid", {31'b0, bus.data_valid}, 32'd0);
      chk("startclr_busy", {31'b0, busy}, 32'd0);

      // asynchronous reset mid-SEND
      send(str2bytes("www.google.com"), 14, 0, 8'h20);
      tick();
      #2 n_rst = 1'b0;
      #1;
      chk("arst_data", bus.data_out, 32'h0);
      chk("arst_valid", {31'b0, bus.data_valid}, 32'd0);
      chk("arst_busy", {31'b0, busy}, 32'd0);
      tick();
      n_rst = 1'b1;
      tick();
      chk("arst_idle_valid", {31'b0, bus.data_valid}, 32'd0);
      chk("arst_idle_busy", {31'b0, busy}, 32'd0);
      send(str2bytes("abc"), 3, 1, 8'h2E);
      exp_q = '{".abc"};
      expect_stream("after_reset");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
